// File: rtl/vga_scan_sink.sv
// VGA 640x480@60 scan engine: requests game-field pixels at 2x scale and drives
// registered RGB/sync/de, with sync and blank delayed to match the pixel-source latency.
module vga_scan_sink #(
  parameter int          H_ACTIVE     = 640,
  parameter int          H_FP         = 16,
  parameter int          H_SYNC       = 96,
  parameter int          H_BP         = 48,
  parameter int          V_ACTIVE     = 480,
  parameter int          V_FP         = 10,
  parameter int          V_SYNC       = 2,
  parameter int          V_BP         = 33,
  parameter int          GAME_W       = 300,
  parameter int          GAME_H       = 240,
  parameter int          SCALE_SHIFT  = 1,
  parameter int          X_OFF        = 20,
  parameter int          Y_OFF        = 0,
  parameter int          PIX_LAT      = 2,
  parameter logic [23:0] BORDER_COLOR = 24'h000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scan_en,
  output logic [9:0]  current_print_row,
  output logic [9:0]  current_print_column,
  input  logic [23:0] background_pixel,
  input  logic        background_pixel_valid,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_de,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic [9:0]  hcnt, vcnt;
  logic [10:0] hoff, voff;
  logic        active0, hs0, vs0, ingame0;

  logic        act1, hs1, vs1, ing1;
  logic [PIX_LAT-1:0] act_d, hs_d, vs_d, ing_d;
  logic [23:0] rgb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (!scan_en) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == 10'(H_TOTAL - 1)) begin
      hcnt <= '0;
      vcnt <= (vcnt == 10'(V_TOTAL - 1)) ? '0 : vcnt + 10'd1;
    end else begin
      hcnt <= hcnt + 10'd1;
    end
  end

  // Offsets wrap to large values left of / above the field, so one unsigned
  // compare per axis covers both ends of the game window.
  assign hoff    = {1'b0, hcnt} - 11'(X_OFF);
  assign voff    = {1'b0, vcnt} - 11'(Y_OFF);
  assign active0 = (hcnt < 10'(H_ACTIVE)) && (vcnt < 10'(V_ACTIVE));
  assign hs0     = !((hcnt >= 10'(H_ACTIVE + H_FP)) && (hcnt < 10'(H_ACTIVE + H_FP + H_SYNC)));
  assign vs0     = !((vcnt >= 10'(V_ACTIVE + V_FP)) && (vcnt < 10'(V_ACTIVE + V_FP + V_SYNC)));
  assign ingame0 = (hoff < 11'(GAME_W << SCALE_SHIFT)) && (voff < 11'(GAME_H << SCALE_SHIFT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      current_print_row    <= '0;
      current_print_column <= '0;
      frame_start          <= 1'b0;
      act1                 <= 1'b0;
      hs1                  <= 1'b1;
      vs1                  <= 1'b1;
      ing1                 <= 1'b0;
    end else begin
      act1        <= scan_en && active0;
      hs1         <= !scan_en || hs0;
      vs1         <= !scan_en || vs0;
      ing1        <= scan_en && ingame0;
      frame_start <= scan_en && (hcnt == 10'd0) && (vcnt == 10'd0);
      if (scan_en && ingame0) begin
        current_print_column <= 10'(hoff >> SCALE_SHIFT);
        current_print_row    <= 10'(voff >> SCALE_SHIFT);
      end else begin
        current_print_column <= '0;
        current_print_row    <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_d <= '0;
      hs_d  <= '1;
      vs_d  <= '1;
      ing_d <= '0;
    end else begin
      act_d[0] <= act1;
      hs_d[0]  <= hs1;
      vs_d[0]  <= vs1;
      ing_d[0] <= ing1;
      for (int i = 1; i < PIX_LAT; i++) begin
        act_d[i] <= act_d[i-1];
        hs_d[i]  <= hs_d[i-1];
        vs_d[i]  <= vs_d[i-1];
        ing_d[i] <= ing_d[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb    <= '0;
      vga_hs <= 1'b1;
      vga_vs <= 1'b1;
      vga_de <= 1'b0;
    end else begin
      vga_de <= act_d[PIX_LAT-1];
      vga_hs <= hs_d[PIX_LAT-1];
      vga_vs <= vs_d[PIX_LAT-1];
      if (!act_d[PIX_LAT-1])
        rgb <= '0;
      else if (!ing_d[PIX_LAT-1] || !background_pixel_valid)
        rgb <= BORDER_COLOR;
      else
        rgb <= background_pixel;
    end
  end

  assign vga_r = rgb[23:16];
  assign vga_g = rgb[15:8];
  assign vga_b = rgb[7:0];

endmodule

// File: doc/vga_scan_sink.md
Name: vga_scan_sink

Overview:
- Display-side counterpart of the background/sprite pixel generators: the VGA scan engine that drives current_print_row/current_print_column and consumes the returned 24-bit pixel.
- Generates 640x480@60 timing on a 25 MHz pixel clock and maps the 300x240 game field onto the screen at 2x scale, with a horizontal offset.
- Delays sync/blank through a pipeline matched to pixel-source latency and drives registered RGB/hsync/vsync to the DAC.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- GAME_W, 300, game columns
- GAME_H, 240, game rows
- SCALE_SHIFT, 1, screen-to-game shift (2x)
- X_OFF, 20, screen column of game column 0
- Y_OFF, 0, screen line of game row 0
- PIX_LAT, 2, clocks from coordinate output to valid background_pixel (1..4)
- BORDER_COLOR, 24'h000000, colour outside game field inside the active area

Ports:
- clk  in  1  pixel clock, 25 MHz
- rst_n  in  1  asynchronous, active-low reset
- scan_en  in  1  scan run enable
- current_print_row  out  10  game row requested
- current_print_column  out  10  game column requested
- background_pixel  in  24  RGB 8:8:8 returned by pixel source
- background_pixel_valid  in  1  pixel valid qualifier
- vga_r, vga_g, vga_b  out  8 each  DAC colour
- vga_hs  out  1  hsync, active low
- vga_vs  out  1  vsync, active low
- vga_de  out  1  active-video flag, aligned with RGB
- frame_start  out  1  one-clock pulse at the start of each frame

Behaviour:
- Reset: the clock is clk; the reset is rst_n, asynchronous, active-low. On reset, hcnt=0, vcnt=0, all delay stages cleared, coordinates=0, RGB=0, vga_hs=1, vga_vs=1, vga_de=0, frame_start=0.
- Counters:
  - hcnt runs 0..H_TOTAL-1 (800) and wraps to 0.
  - vcnt increments when hcnt wraps, runs 0..V_TOTAL-1 (525), and wraps to 0.
  - Both advance only while scan_en=1.
- Stop and restart:
  - scan_en=0: counters are forced to 0 the next clock, and the pipeline keeps shifting blank stages (de=0, hs=1, vs=1).
  - Re-enable: the scan restarts at (0,0).
- Stage 0 (counters at cycle t):
  - active = hcnt<H_ACTIVE && vcnt<V_ACTIVE.
  - hs_n = !(hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]), which is 656..751.
  - vs_n = !(vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]), which is 490..491.
  - ingame = hcnt in [X_OFF, X_OFF+(GAME_W<<SCALE_SHIFT)-1] and vcnt in [Y_OFF, Y_OFF+(GAME_H<<SCALE_SHIFT)-1].
- Stage 1 (cycle t+1, registered):
  - If ingame: current_print_column=(hcnt-X_OFF)>>SCALE_SHIFT and current_print_row=(vcnt-Y_OFF)>>SCALE_SHIFT. Subtractions are done at 11 bits and truncated to 10 bits.
  - Otherwise both coordinates are 0.
  - frame_start=1 in the cycle the coordinates for hcnt=0,vcnt=0 are presented, and only while scan_en=1.
- Delay line: active, hs_n, vs_n and ingame are delayed PIX_LAT further stages (shift register) to align with background_pixel.
- Output register (cycle t+2+PIX_LAT):
  - vga_de = active_d.
  - vga_hs = hs_n_d; vga_vs = vs_n_d.
  - RGB is selected as follows:
    - !active_d -> 0.
    - active_d && (!ingame_d || !background_pixel_valid) -> BORDER_COLOR.
    - Otherwise -> background_pixel. R=[23:16], G=[15:8], B=[7:0].
- Latency: every output is aligned with the same latency, PIX_LAT+2 clocks from the counter value. There is no relative skew between sync, de and RGB.
- Reset mid-frame: an immediate asynchronous return to the reset values. The scan resumes at (0,0) after release.

Test Plan:
- Reset release with scan_en=1 -> frame_start pulses at cycle 1 and every 420000 clocks thereafter; vga_hs low exactly 96 clocks per 800; vga_vs low exactly 2 lines (1600 clocks) per frame.
- Stub source returning {row,column,4'h0} after PIX_LAT=2 clocks -> at screen (x=20,y=0) RGB={10'd0,10'd0,4'h0}; at (x=619,y=479) column=299, row=239; the pair x=21/x=20 returns the same column (2x scale).
- Screen x=0..19 and x=620..639 active -> RGB=BORDER_COLOR and current_print_column=0; x>=640 -> RGB=0 and vga_de=0.
- Sweep PIX_LAT=1,3,4 with matching stub -> vga_de edges coincide with the first and last valid pixel of each line, with no one-pixel shift.
- background_pixel_valid forced 0 for one line -> that line shows BORDER_COLOR in the game field; sync timing unchanged.
- scan_en dropped mid-line at hcnt=300,vcnt=100 then raised -> within PIX_LAT+2 clocks vga_de=0, hs=1, vs=1; after raise, frame_start pulses and the next hsync starts 656 clocks later. Async reset asserted mid-frame -> outputs go to reset values without waiting for a clock edge.
